// File: rtl/cceip_outbound.sv
// cceip_outbound: drops the CCEIP response prefix, forwards payload beats to the
// memory-writer AXIS through a 1-entry register slice, drops trailer beats up to tlast.
// Optional build macro: CCEIP_OUTBOUND_TIMEOUT_EN enables the idle-input abort counter.
module cceip_outbound #(
    parameter int unsigned PREFIX_BEATS   = 2,
    parameter int unsigned TIMEOUT_CYCLES = 65536
) (
    input  logic        ap_clk,
    input  logic        ap_rst_n,
    input  logic        outbound_start,
    output logic        outbound_done,
    output logic [63:0] output_data_size,
    output logic [63:0] outbound_status,
    output logic [2:0]  outbound_error,
    input  logic        cceip_s_axis_tvalid,
    output logic        cceip_s_axis_tready,
    input  logic        cceip_s_axis_tlast,
    input  logic [7:0]  cceip_s_axis_tstrb,
    input  logic [7:0]  cceip_s_axis_tuser,
    input  logic        cceip_s_axis_tid,
    input  logic [63:0] cceip_s_axis_tdata,
    output logic        mm_m_axis_tvalid,
    input  logic        mm_m_axis_tready,
    output logic        mm_m_axis_tlast,
    output logic [7:0]  mm_m_axis_tkeep,
    output logic [63:0] mm_m_axis_tdata
);

    typedef enum logic [2:0] {SIdle, SPrefix, SData, STrailer, SDrain, SDone} state_e;

    localparam logic [3:0] PfxLast = 4'(PREFIX_BEATS - 1);

    state_e      state_q, state_d;
    logic [3:0]  pfx_q, pfx_d;
    logic [63:0] size_q, size_d;
    logic [63:0] status_q, status_d;
    logic [2:0]  err_q, err_d;
    logic        ov_q, ov_d;
    logic [63:0] od_q, od_d;
    logic [7:0]  ok_q, ok_d;
    logic        ol_q, ol_d;
    logic        in_hs;
    logic        timeout_hit;
    logic        unused_ok;

    // tid, upper tuser bits and (in the default build) the timeout length are not used
    assign unused_ok = ^{cceip_s_axis_tid, cceip_s_axis_tuser[7:2], TIMEOUT_CYCLES != 0};

    function automatic logic [3:0] popcnt8(input logic [7:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) c = c + {3'd0, v[i]};
        return c;
    endfunction

    // Input ready: the slice accepts a new beat when empty or draining this cycle
    always_comb begin
        cceip_s_axis_tready = 1'b0;
        unique case (state_q)
            SPrefix, STrailer: cceip_s_axis_tready = 1'b1;
            SData:             cceip_s_axis_tready = !ov_q || mm_m_axis_tready;
            default:           cceip_s_axis_tready = 1'b0;
        endcase
    end

    assign in_hs = cceip_s_axis_tvalid && cceip_s_axis_tready;

`ifdef CCEIP_OUTBOUND_TIMEOUT_EN
    logic [31:0] idle_q, idle_d;

    // Idle-input counter: runs in SData/STrailer, cleared by any input handshake
    always_comb begin
        idle_d      = idle_q;
        timeout_hit = 1'b0;
        if (state_q == SIdle && outbound_start) begin
            idle_d = 32'd0;
        end else if (state_q == SData || state_q == STrailer) begin
            if (in_hs) begin
                idle_d = 32'd0;
            end else if (idle_q == TIMEOUT_CYCLES - 32'd1) begin
                timeout_hit = 1'b1;
                idle_d      = 32'd0;
            end else begin
                idle_d = idle_q + 32'd1;
            end
        end
    end

    // Idle counter state
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) idle_q <= 32'd0;
        else           idle_q <= idle_d;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Next-state logic for the FSM, counters, status and the output slice
    always_comb begin
        state_d  = state_q;
        pfx_d    = pfx_q;
        size_d   = size_q;
        status_d = status_q;
        err_d    = err_q;
        ov_d     = ov_q;
        od_d     = od_q;
        ok_d     = ok_q;
        ol_d     = ol_q;
        if (ov_q && mm_m_axis_tready) ov_d = 1'b0;
        unique case (state_q)
            SIdle: begin
                if (outbound_start) begin
                    state_d  = SPrefix;
                    pfx_d    = 4'd0;
                    size_d   = 64'd0;
                    status_d = 64'd0;
                    err_d    = 3'd0;
                end
            end
            SPrefix: begin
                if (in_hs) begin
                    if (cceip_s_axis_tlast) begin
                        err_d[0] = 1'b1;
                        state_d  = SDone;
                    end else if (pfx_q == PfxLast) begin
                        state_d = SData;
                    end else begin
                        pfx_d = pfx_q + 4'd1;
                    end
                end
            end
            SData: begin
                if (in_hs) begin
                    if (cceip_s_axis_tstrb != 8'd0) begin
                        ov_d = 1'b1;
                        od_d = cceip_s_axis_tdata;
                        ok_d = cceip_s_axis_tstrb;
                        ol_d = cceip_s_axis_tuser[1];
                    end
                    size_d = size_q + {60'd0, popcnt8(cceip_s_axis_tstrb)};
                    // Contiguous LSB strobes satisfy s & (s+1) == 0
                    if ((cceip_s_axis_tstrb & (cceip_s_axis_tstrb + 8'd1)) != 8'd0) err_d[1] = 1'b1;
                    if (cceip_s_axis_tuser[1]) begin
                        state_d = cceip_s_axis_tlast ? SDrain : STrailer;
                    end else if (cceip_s_axis_tlast) begin
                        err_d[0] = 1'b1;
                        state_d  = SDrain;
                    end
                end else if (timeout_hit) begin
                    err_d[2] = 1'b1;
                    state_d  = SDrain;
                end
            end
            STrailer: begin
                if (in_hs) begin
                    status_d = cceip_s_axis_tdata;
                    if (cceip_s_axis_tlast) state_d = SDrain;
                end else if (timeout_hit) begin
                    err_d[2] = 1'b1;
                    state_d  = SDrain;
                end
            end
            SDrain:  if (!ov_q) state_d = SDone;
            SDone:   state_d = SIdle;
            default: state_d = SIdle;
        endcase
    end

    // All block state; async reset drops any held output beat
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q  <= SIdle;
            pfx_q    <= 4'd0;
            size_q   <= 64'd0;
            status_q <= 64'd0;
            err_q    <= 3'd0;
            ov_q     <= 1'b0;
            od_q     <= 64'd0;
            ok_q     <= 8'd0;
            ol_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            pfx_q    <= pfx_d;
            size_q   <= size_d;
            status_q <= status_d;
            err_q    <= err_d;
            ov_q     <= ov_d;
            od_q     <= od_d;
            ok_q     <= ok_d;
            ol_q     <= ol_d;
        end
    end

    assign outbound_done    = (state_q == SDone);
    assign output_data_size = size_q;
    assign outbound_status  = status_q;
    assign outbound_error   = err_q;
    assign mm_m_axis_tvalid = ov_q;
    assign mm_m_axis_tdata  = od_q;
    assign mm_m_axis_tkeep  = ok_q;
    assign mm_m_axis_tlast  = ol_q;

endmodule
